// File: rtl/tnn_neuron_sequencer_if.sv
// Handshake and neuron-operand bundle between the sequencer, its sample
// producer, the shared combinational neuron and the result consumer.
interface tnn_neuron_sequencer_if #(
  parameter int N_NEURON = 4,
  parameter int CW       = $clog2(N_NEURON + 1)
);
  logic                    in_valid;
  logic                    in_ready;
  logic [9*N_NEURON-1:0]   in_feat;
  logic [2:0]              neu_a;
  logic [2:0]              neu_b;
  logic [2:0]              neu_c;
  logic                    neu_out;
  logic                    out_valid;
  logic                    out_ready;
  logic [CW-1:0]           out_count;
  logic                    out_class;
  logic                    busy;

  modport master (
    output in_valid, in_feat, neu_out, out_ready,
    input  in_ready, neu_a, neu_b, neu_c, out_valid, out_count, out_class, busy
  );

  modport slave (
    input  in_valid, in_feat, neu_out, out_ready,
    output in_ready, neu_a, neu_b, neu_c, out_valid, out_count, out_class, busy
  );
endinterface

// File: rtl/tnn_neuron_sequencer.sv
// Time-multiplexes one combinational 3-bit TNN neuron over N_NEURON operand
// triples of a captured sample and reports the fire count plus a class bit.
//
// state | meaning
// IDLE  | ready for a sample; neuron operands forced to 0
// RUN   | feeding triple idx to the neuron, accumulating fire bits
// DONE  | result valid, held until the consumer accepts it
module tnn_neuron_sequencer #(
  parameter int N_NEURON = 4,
  parameter int THRESH   = 2,
  parameter int CW       = $clog2(N_NEURON + 1)
) (
  input logic                 clk,
  input logic                 rst,
  tnn_neuron_sequencer_if.slave bus
);
  localparam int IW = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_NEURON - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         acc;
  logic [CW-1:0]         sum;
  logic [9*N_NEURON-1:0] feat;
  logic [8:0]            triple;
  logic [CW-1:0]         count_q;
  logic                  class_q;

  always_comb begin
    triple = '0;
    for (int k = 0; k < N_NEURON; k++) begin
      if (idx == IW'(k)) triple = feat[9*k +: 9];
    end
  end

  assign sum = acc + CW'(bus.neu_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      acc     <= '0;
      feat    <= '0;
      count_q <= '0;
      class_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            feat  <= bus.in_feat;
            idx   <= '0;
            acc   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= sum;
          if (idx == LAST) begin
            count_q <= sum;
            class_q <= (32'(sum) >= THRESH);
            state   <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operands only leave the block while the neuron is actually being used.
  assign bus.neu_a     = (state == RUN) ? triple[2:0] : 3'd0;
  assign bus.neu_b     = (state == RUN) ? triple[5:3] : 3'd0;
  assign bus.neu_c     = (state == RUN) ? triple[8:6] : 3'd0;
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_count = count_q;
  assign bus.out_class = class_q;
endmodule

// File: tb/tb_tnn_neuron_sequencer.sv
// Directed bench for tnn_neuron_sequencer: a 4-triple instance (THRESH=2)
// and a 1-triple instance (THRESH=1) sharing clock and reset.
module tb_tnn_neuron_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tnn_neuron_sequencer_if #(.N_NEURON(4), .CW(3)) ifc ();
  tnn_neuron_sequencer_if #(.N_NEURON(1), .CW(1)) ifc1 ();

  logic [7:0] fire_mask;
  logic       fire1;
  // Bench neuron model: fires according to operand a.
  assign ifc.neu_out  = fire_mask[ifc.neu_a];
  assign ifc1.neu_out = fire1;

  tnn_neuron_sequencer #(.N_NEURON(4), .THRESH(2)) dut (
    .clk(clk), .rst(rst), .bus(ifc)
  );

  tnn_neuron_sequencer #(.N_NEURON(1), .THRESH(1)) dut1 (
    .clk(clk), .rst(rst), .bus(ifc1)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [35:0] PAT = {9'o543, 9'o432, 9'o321, 9'o210};

  task automatic run_sample(input logic [35:0] f, input logic [7:0] m,
                            input logic [2:0] ec, input logic ecls, input int hold);
    fire_mask     = m;
    ifc.in_feat   = f;
    ifc.in_valid  = 1'b1;
    ifc.out_ready = 1'b0;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.in_feat  = ~f;
    for (int k = 0; k < 4; k++) begin
      total++; if (ifc.neu_a !== f[9*k +: 3]) begin bad++; $display("FAIL neu_a k=%0d got=%0d exp=%0d", k, ifc.neu_a, f[9*k +: 3]); end
      total++; if (ifc.neu_b !== f[9*k+3 +: 3]) begin bad++; $display("FAIL neu_b k=%0d got=%0d exp=%0d", k, ifc.neu_b, f[9*k+3 +: 3]); end
      total++; if (ifc.neu_c !== f[9*k+6 +: 3]) begin bad++; $display("FAIL neu_c k=%0d got=%0d exp=%0d", k, ifc.neu_c, f[9*k+6 +: 3]); end
      total++; if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b0 || ifc.busy !== 1'b1) begin
        bad++; $display("FAIL run_flags k=%0d got valid=%b ready=%b busy=%b exp 0 0 1", k, ifc.out_valid, ifc.in_ready, ifc.busy);
      end
      @(negedge clk);
    end
    total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL latency got out_valid=%b exp=1", ifc.out_valid); end
    total++; if (ifc.out_count !== ec) begin bad++; $display("FAIL out_count got=%0d exp=%0d", ifc.out_count, ec); end
    total++; if (ifc.out_class !== ecls) begin bad++; $display("FAIL out_class got=%b exp=%b", ifc.out_class, ecls); end
    if (hold > 0) begin
      ifc.in_valid = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        total++; if (ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0) begin
          bad++; $display("FAIL hold_flags got valid=%b ready=%b exp 1 0", ifc.out_valid, ifc.in_ready);
        end
        total++; if (ifc.out_count !== ec || ifc.out_class !== ecls) begin
          bad++; $display("FAIL hold_result got=%0d/%b exp=%0d/%b", ifc.out_count, ifc.out_class, ec, ecls);
        end
      end
      ifc.in_valid = 1'b0;
    end
    ifc.out_ready = 1'b1;
    @(negedge clk);
    ifc.out_ready = 1'b0;
    total++; if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || ifc.busy !== 1'b0) begin
      bad++; $display("FAIL release got valid=%b ready=%b busy=%b exp 0 1 0", ifc.out_valid, ifc.in_ready, ifc.busy);
    end
    total++; if (ifc.out_count !== ec || ifc.out_class !== ecls) begin
      bad++; $display("FAIL kept_result got=%0d/%b exp=%0d/%b", ifc.out_count, ifc.out_class, ec, ecls);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.in_valid = 1'b0; ifc.in_feat = '0; ifc.out_ready = 1'b0; fire_mask = 8'h00;
    ifc1.in_valid = 1'b0; ifc1.in_feat = '0; ifc1.out_ready = 1'b0; fire1 = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || ifc.busy !== 1'b0) begin
      bad++; $display("FAIL reset_flags got valid=%b ready=%b busy=%b exp 0 1 0", ifc.out_valid, ifc.in_ready, ifc.busy);
    end
    total++; if (ifc.out_count !== 3'd0 || ifc.out_class !== 1'b0) begin
      bad++; $display("FAIL reset_result got=%0d/%b exp=0/0", ifc.out_count, ifc.out_class);
    end
    total++; if ({ifc.neu_a, ifc.neu_b, ifc.neu_c} !== 9'd0) begin
      bad++; $display("FAIL reset_operands got=%o exp=0", {ifc.neu_c, ifc.neu_b, ifc.neu_a});
    end
    total++; if (ifc1.out_valid !== 1'b0 || ifc1.in_ready !== 1'b1 || ifc1.out_count !== 1'b0) begin
      bad++; $display("FAIL reset_n1 got valid=%b ready=%b count=%0d exp 0 1 0", ifc1.out_valid, ifc1.in_ready, ifc1.out_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pattern();
    run_sample(PAT, 8'b0000_1101, 3'd3, 1'b1, 0);
  endtask

  task automatic test_extremes();
    run_sample(PAT, 8'h00, 3'd0, 1'b0, 0);
    run_sample(PAT, 8'hff, 3'd4, 1'b1, 0);
  endtask

  task automatic test_thresh_boundary();
    run_sample(PAT, 8'b0000_0011, 3'd2, 1'b1, 0);
    run_sample(PAT, 8'b0000_1000, 3'd1, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    run_sample(PAT, 8'b0000_1101, 3'd3, 1'b1, 6);
  endtask

  task automatic test_reset_mid_run();
    fire_mask    = 8'hff;
    ifc.in_feat  = PAT;
    ifc.in_valid = 1'b1;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (ifc.neu_a !== 3'd2) begin bad++; $display("FAIL midrun_idx got neu_a=%0d exp=2", ifc.neu_a); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || ifc.busy !== 1'b0) begin
      bad++; $display("FAIL midrun_flags got valid=%b ready=%b busy=%b exp 0 1 0", ifc.out_valid, ifc.in_ready, ifc.busy);
    end
    total++; if (ifc.out_count !== 3'd0 || ifc.out_class !== 1'b0) begin
      bad++; $display("FAIL midrun_result got=%0d/%b exp=0/0", ifc.out_count, ifc.out_class);
    end
    total++; if ({ifc.neu_a, ifc.neu_b, ifc.neu_c} !== 9'd0) begin
      bad++; $display("FAIL midrun_operands got=%o exp=0", {ifc.neu_c, ifc.neu_b, ifc.neu_a});
    end
    run_sample(PAT, 8'b0000_0101, 3'd2, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    logic [35:0] s   [3];
    logic [2:0]  ec  [3];
    logic        ecl [3];
    s[0] = PAT;                                      ec[0] = 3'd2; ecl[0] = 1'b1;
    s[1] = {9'o001, 9'o001, 9'o001, 9'o001};         ec[1] = 3'd4; ecl[1] = 1'b1;
    s[2] = {9'o000, 9'o000, 9'o000, 9'o012};         ec[2] = 3'd1; ecl[2] = 1'b0;
    fire_mask     = 8'b0000_0110;
    ifc.out_ready = 1'b1;
    ifc.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifc.in_feat = s[i];
      total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_accept i=%0d got in_ready=%b exp=1", i, ifc.in_ready); end
      @(negedge clk);
      ifc.in_feat = ~s[i];
      for (int k = 0; k < 4; k++) begin
        total++; if ({ifc.neu_c, ifc.neu_b, ifc.neu_a} !== s[i][9*k +: 9]) begin
          bad++; $display("FAIL b2b_operands i=%0d k=%0d got=%o exp=%o", i, k, {ifc.neu_c, ifc.neu_b, ifc.neu_a}, s[i][9*k +: 9]);
        end
        @(negedge clk);
      end
      total++; if (ifc.out_valid !== 1'b1 || ifc.out_count !== ec[i] || ifc.out_class !== ecl[i]) begin
        bad++; $display("FAIL b2b_result i=%0d got valid=%b %0d/%b exp 1 %0d/%b", i, ifc.out_valid, ifc.out_count, ifc.out_class, ec[i], ecl[i]);
      end
      if (i == 2) ifc.in_valid = 1'b0;
      @(negedge clk);
    end
    ifc.out_ready = 1'b0;
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got busy=%b exp=0", ifc.busy); end
  endtask

  task automatic test_single();
    for (int r = 0; r < 2; r++) begin
      fire1          = (r == 0);
      ifc1.in_feat   = 9'o765;
      ifc1.in_valid  = 1'b1;
      @(negedge clk);
      ifc1.in_valid  = 1'b0;
      ifc1.in_feat   = 9'o000;
      total++; if ({ifc1.neu_c, ifc1.neu_b, ifc1.neu_a} !== 9'o765 || ifc1.out_valid !== 1'b0) begin
        bad++; $display("FAIL n1_run r=%0d got ops=%o valid=%b exp 765 0", r, {ifc1.neu_c, ifc1.neu_b, ifc1.neu_a}, ifc1.out_valid);
      end
      @(negedge clk);
      total++; if (ifc1.out_valid !== 1'b1 || ifc1.out_count !== fire1 || ifc1.out_class !== fire1) begin
        bad++; $display("FAIL n1_result r=%0d got valid=%b %0d/%b exp 1 %0d/%b", r, ifc1.out_valid, ifc1.out_count, ifc1.out_class, fire1, fire1);
      end
      ifc1.out_ready = 1'b1;
      @(negedge clk);
      ifc1.out_ready = 1'b0;
      total++; if (ifc1.out_valid !== 1'b0 || ifc1.in_ready !== 1'b1) begin
        bad++; $display("FAIL n1_release r=%0d got valid=%b ready=%b exp 0 1", r, ifc1.out_valid, ifc1.in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_extremes();
    test_thresh_boundary();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
